// File: rtl/clint_pkg.sv
// Shared constants and types for the core-local interruptor.
// Register offsets, bus FSM encoding and reset values.
package clint_pkg;

  localparam logic [15:0] CLINT_MSIP        = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
  localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
  localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
  localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } clint_state_e;

  typedef struct packed {
    logic msip;
    logic cmp_lo;
    logic cmp_hi;
    logic mtime_lo;
    logic mtime_hi;
  } clint_sel_t;

endpackage

// File: rtl/clint_prescaler.sv
// mtime prescaler: one tick every TICK_DIV clk_i cycles.
// A clear restarts the count so a fresh mtime value gets a full period.
module clint_prescaler #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  output logic tick_o
);

  localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

  logic [15:0] cnt;

  assign tick_o = (cnt == LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (clear_i || tick_o) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/clint.sv
// Core-local interruptor: mtime, mtimecmp and msip behind a 32-bit slave port.
// Drives the machine timer and software interrupt levels for csrfile.
module clint
  import clint_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned ADDR_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              ready_o,
  output logic              rvalid_o,
  output logic [31:0]       rdata_o,
  output logic              timer_irq_o,
  output logic              software_irq_o,
  output logic [63:0]       mtime_o
);

  clint_state_e      state;
  clint_sel_t        sel;
  logic [ADDR_W-1:0] word;
  logic              accept;
  logic              wr;
  logic              tick;
  logic              mtime_wr;
  logic [63:0]       mtime_q;
  logic [63:0]       mtime_d;
  logic [63:0]       cmp_q;
  logic [63:0]       cmp_d;
  logic              msip_q;
  logic              msip_d;
  logic [31:0]       rdata_d;
  logic              unused_addr;

  assign unused_addr = ^addr_i[1:0];
  assign word        = {addr_i[ADDR_W-1:2], 2'b00};

  always_comb begin
    sel = '0;
    unique case (1'b1)
      (word == ADDR_W'(CLINT_MSIP)):        sel.msip     = 1'b1;
      (word == ADDR_W'(CLINT_MTIMECMP_LO)): sel.cmp_lo   = 1'b1;
      (word == ADDR_W'(CLINT_MTIMECMP_HI)): sel.cmp_hi   = 1'b1;
      (word == ADDR_W'(CLINT_MTIME_LO)):    sel.mtime_lo = 1'b1;
      (word == ADDR_W'(CLINT_MTIME_HI)):    sel.mtime_hi = 1'b1;
      default: ;
    endcase
  end

  assign accept   = (state == IDLE) && req_i;
  assign wr       = accept && we_i;
  assign mtime_wr = wr && (sel.mtime_lo || sel.mtime_hi);

  clint_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (mtime_wr),
    .tick_o  (tick)
  );

  // A write to either half wins over the tick; the carry is one 64-bit add.
  always_comb begin
    mtime_d = mtime_q;
    if (wr && sel.mtime_lo) begin
      mtime_d[31:0] = wdata_i;
    end else if (wr && sel.mtime_hi) begin
      mtime_d[63:32] = wdata_i;
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  always_comb begin
    cmp_d = cmp_q;
    if (wr && sel.cmp_lo) begin
      cmp_d[31:0] = wdata_i;
    end else if (wr && sel.cmp_hi) begin
      cmp_d[63:32] = wdata_i;
    end
  end

  assign msip_d = (wr && sel.msip) ? wdata_i[0] : msip_q;

  always_comb begin
    rdata_d = '0;
    unique case (1'b1)
      sel.msip:     rdata_d = {31'b0, msip_q};
      sel.cmp_lo:   rdata_d = cmp_q[31:0];
      sel.cmp_hi:   rdata_d = cmp_q[63:32];
      sel.mtime_lo: rdata_d = mtime_q[31:0];
      sel.mtime_hi: rdata_d = mtime_q[63:32];
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtime_q        <= '0;
      cmp_q          <= MTIMECMP_RST;
      msip_q         <= 1'b0;
      timer_irq_o    <= 1'b0;
      software_irq_o <= 1'b0;
    end else begin
      mtime_q        <= mtime_d;
      cmp_q          <= cmp_d;
      msip_q         <= msip_d;
      timer_irq_o    <= (mtime_d >= cmp_d);
      software_irq_o <= msip_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      ready_o  <= 1'b0;
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_i) begin
            state    <= ACK;
            ready_o  <= 1'b1;
            rvalid_o <= ~we_i;
            if (!we_i) begin
              rdata_o <= rdata_d;
            end
          end
        end
        ACK: begin
          state    <= IDLE;
          ready_o  <= 1'b0;
          rvalid_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mtime_o = mtime_q;

endmodule

// File: tb/tb_clint.sv
// Bench for clint: two instances (TICK_DIV 4 and 1) on one bus,
// checked every cycle against a behavioural register model.
module tb_clint;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [15:0] addr = '0;
  logic [31:0] wdata = '0;

  logic        ready [2];
  logic        rvalid [2];
  logic [31:0] rdata [2];
  logic        tirq [2];
  logic        sirq [2];
  logic [63:0] mtime [2];

  int checks = 0;
  int errs = 0;

  always #5 clk = ~clk;

  clint #(.TICK_DIV(4), .ADDR_W(16)) u4 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we),
    .addr_i(addr), .wdata_i(wdata),
    .ready_o(ready[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]),
    .timer_irq_o(tirq[0]), .software_irq_o(sirq[0]),
    .mtime_o(mtime[0])
  );

  clint #(.TICK_DIV(1), .ADDR_W(16)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we),
    .addr_i(addr), .wdata_i(wdata),
    .ready_o(ready[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]),
    .timer_irq_o(tirq[1]), .software_irq_o(sirq[1]),
    .mtime_o(mtime[1])
  );

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  // Behavioural model: registers as plain integers, mtime ticks every
  // div cycles counted since reset or the last mtime write.
  longint unsigned m_time [2];
  longint unsigned m_cmp [2];
  bit              m_msip [2];
  int              m_pc [2];
  bit [31:0]       m_rdata [2];
  bit              m_ack = 0;
  bit              m_rvalid = 0;

  function automatic int div_of(int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_time[k] = 0;
      m_cmp[k] = 64'hFFFF_FFFF_FFFF_FFFF;
      m_msip[k] = 0;
      m_pc[k] = 0;
      m_rdata[k] = 0;
    end
    m_ack = 0;
    m_rvalid = 0;
  endfunction

  function automatic bit [31:0] model_read(int k, logic [15:0] w);
    case (w)
      16'h0000: return {31'b0, m_msip[k]};
      16'h4000: return m_cmp[k][31:0];
      16'h4004: return m_cmp[k][63:32];
      16'hBFF8: return m_time[k][31:0];
      16'hBFFC: return m_time[k][63:32];
      default:  return 32'h0;
    endcase
  endfunction

  function automatic void model_step(int k, bit acc);
    logic [15:0] w;
    bit tick;
    w = {addr[15:2], 2'b00};
    tick = (m_pc[k] == div_of(k) - 1);
    if (acc && !we) m_rdata[k] = model_read(k, w);
    if (acc && we && (w == 16'hBFF8 || w == 16'hBFFC)) begin
      if (w == 16'hBFF8) m_time[k][31:0] = wdata;
      else m_time[k][63:32] = wdata;
      m_pc[k] = 0;
    end else begin
      if (tick) m_time[k] = m_time[k] + 1;
      m_pc[k] = (m_pc[k] + 1) % div_of(k);
    end
    if (acc && we) begin
      if (w == 16'h4000) m_cmp[k][31:0] = wdata;
      if (w == 16'h4004) m_cmp[k][63:32] = wdata;
      if (w == 16'h0000) m_msip[k] = wdata[0];
    end
  endfunction

  initial model_reset();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      bit acc;
      acc = req && !m_ack;
      model_step(0, acc);
      model_step(1, acc);
      m_ack = acc;
      m_rvalid = acc && !we;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ready%0d", k), 64'(ready[k]), 64'(m_ack));
      chk($sformatf("rvalid%0d", k), 64'(rvalid[k]), 64'(m_rvalid));
      chk($sformatf("rdata%0d", k), 64'(rdata[k]), 64'(m_rdata[k]));
      chk($sformatf("mtime%0d", k), mtime[k], m_time[k]);
      chk($sformatf("tirq%0d", k), 64'(tirq[k]),
          64'(m_time[k] >= m_cmp[k]));
      chk($sformatf("sirq%0d", k), 64'(sirq[k]), 64'(m_msip[k]));
    end
  end

  logic [31:0] a_rd [2];
  logic [63:0] a_mt [2];
  logic        a_ti [2];
  logic        a_si [2];

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the ACK cycle.
  task automatic bus(input bit w, input logic [15:0] a,
                     input logic [31:0] d);
    int n;
    req = 1'b1;
    we = w;
    addr = a;
    wdata = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready[0] && n < 4);
    chk("latency", 64'(n), 64'd2);
    for (int k = 0; k < 2; k++) begin
      a_rd[k] = rdata[k];
      a_mt[k] = mtime[k];
      a_ti[k] = tirq[k];
      a_si[k] = sirq[k];
    end
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  logic [15:0] amap [8];

  initial begin
    amap = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8,
             16'hBFFC, 16'h0004, 16'h8000, 16'h0000};
    cyc(3);
    rst_n = 1'b1;
    cyc(40);
    chk("idle40_lo", 64'(mtime[0] >= 9), 64'd1);
    chk("idle40_hi", 64'(mtime[0] <= 11), 64'd1);

    bus(0, 16'h4000, 0);
    chk("rst_cmp_lo", 64'(a_rd[0]), 64'hFFFF_FFFF);
    bus(0, 16'h4004, 0);
    chk("rst_cmp_hi", 64'(a_rd[1]), 64'hFFFF_FFFF);
    bus(0, 16'hBFF8, 0);
    chk("rst_mtime_small", 64'(a_rd[0] < 20), 64'd1);
    chk("rst_tirq", 64'(a_ti[0] | a_ti[1]), 64'd0);
    chk("rst_sirq", 64'(a_si[0] | a_si[1]), 64'd0);

    bus(1, 16'hBFFC, 0);
    bus(1, 16'hBFF8, 32'hFFFF_FFFF);
    chk("carry_wr4", a_mt[0], 64'hFFFF_FFFF);
    chk("carry_wr1", a_mt[1], 64'hFFFF_FFFF);
    chk("carry_1", mtime[1], 64'h1_0000_0000);
    cyc(2);
    chk("carry_4_pre", mtime[0], 64'hFFFF_FFFF);
    cyc(1);
    chk("carry_4", mtime[0], 64'h1_0000_0000);

    bus(1, 16'h0000, 32'hFFFF_FFFF);
    chk("msip_set", 64'(a_si[1]), 64'd1);
    bus(0, 16'h0000, 0);
    chk("msip_rd", 64'(a_rd[0]), 64'd1);
    bus(1, 16'h0002, 32'h0);
    chk("msip_clr", 64'(a_si[0]), 64'd0);

    bus(1, 16'h4004, 32'hFFFF_FFFF);
    bus(1, 16'h4000, 32'd100);
    bus(1, 16'h4004, 32'd0);
    bus(1, 16'hBFFC, 32'd0);
    bus(1, 16'hBFF8, 32'd90);
    chk("irq_mt90", a_mt[1], 64'd90);
    chk("irq_low", 64'(a_ti[1]), 64'd0);
    cyc(7);
    chk("irq_pre", 64'(tirq[1]), 64'd0);
    cyc(3);
    chk("irq_hit", 64'(tirq[1]), 64'd1);
    bus(1, 16'h4004, 32'hFFFF_FFFF);
    chk("irq_drop", 64'(a_ti[1]), 64'd0);

    for (int i = 0; i < 300; i++) begin
      logic [15:0] a;
      logic [31:0] d;
      a = amap[$urandom_range(0, 7)];
      if ($urandom_range(0, 7) == 0) a = 16'($urandom);
      d = $urandom;
      if ((a == 16'h4004 || a == 16'hBFFC) && $urandom_range(0, 1) == 1)
        d = 32'($urandom_range(0, 1));
      bus(1'($urandom_range(0, 1)), a, d);
      cyc($urandom_range(0, 3));
    end

    bus(1, 16'hBFFC, 32'd0);
    bus(1, 16'hBFF8, 32'h1234);
    chk("same_edge1", a_mt[1], 64'h1234);
    chk("same_edge4", a_mt[0], 64'h1234);

    req = 1'b1;
    we = 1'b1;
    addr = 16'h4000;
    wdata = 32'h5;
    @(posedge clk);
    #1;
    chk("in_ack", 64'(ready[0]), 64'd1);
    rst_n = 1'b0;
    req = 1'b0;
    #1;
    chk("rst_ack0", 64'(ready[0] | ready[1]), 64'd0);
    chk("rst_mtime", mtime[1], 64'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    chk("post_rst_ready", 64'(ready[0] | ready[1]), 64'd0);
    bus(0, 16'h4000, 0);
    chk("post_rst_cmp", 64'(a_rd[1]), 64'hFFFF_FFFF);
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
